// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and widths used by the ALU, its arbiter and the core.
package alu_pkg;
   localparam int ALU_OPW = 4;

   localparam logic [ALU_OPW-1:0] ALU_AND = 4'b0000;
   localparam logic [ALU_OPW-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALU_OPW-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_OPW-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALU_OPW-1:0] ALU_SLT = 4'b0111;
   localparam logic [ALU_OPW-1:0] ALU_NOR = 4'b1100;
endpackage

// File: rtl/alu.sv
// Shared combinational ALU; unknown opcodes yield a zero result.
module alu
   import alu_pkg::*;
#(
   parameter int SIZE = 32
) (
   input  logic [SIZE-1:0]    a,
   input  logic [SIZE-1:0]    b,
   input  logic [ALU_OPW-1:0] op,
   output logic [SIZE-1:0]    rez,
   output logic               zero
);

   always_comb begin
      rez = '0;
      case (op)
         ALU_AND: rez = a & b;
         ALU_OR:  rez = a | b;
         ALU_ADD: rez = a + b;
         ALU_SUB: rez = a - b;
         ALU_SLT: rez = {{(SIZE-1){1'b0}}, (a < b)};
         ALU_NOR: rez = ~(a | b);
         default: rez = '0;
      endcase
   end

   assign zero = (rez == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from a registered pointer.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id,
   output logic            grant_valid
);

   logic [IDW-1:0] ptr_reg;
   logic [IDW-1:0] ptr_next;
   logic [IDW:0]   sum;
   logic [IDW-1:0] idx;

   // Sum is one bit wider so ptr+k can be folded back below NREQ for non-power-of-two sizes.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      sum         = '0;
      idx         = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr_reg} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NREQ)) begin
            sum = sum - (IDW+1)'(NREQ);
         end
         idx = sum[IDW-1:0];
         if (en && !grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_id    = idx;
         end
      end
      grant = grant_valid ? (NREQ'(1) << grant_id) : '0;
   end

   always_comb begin
      ptr_next = ptr_reg;
      if (grant_valid) begin
         ptr_next = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters with round-robin grant and a one-entry response buffer.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter  int SIZE = 32,
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*SIZE-1:0]    req_rd1,
   input  logic [NREQ*SIZE-1:0]    req_rd2,
   input  logic [NREQ*ALU_OPW-1:0] req_op,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [IDW-1:0]          resp_id,
   output logic [SIZE-1:0]         resp_rez,
   output logic                    resp_zero
);

   logic [SIZE-1:0]    rd1_arr [NREQ];
   logic [SIZE-1:0]    rd2_arr [NREQ];
   logic [ALU_OPW-1:0] op_arr  [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign rd1_arr[gi] = req_rd1[gi*SIZE +: SIZE];
         assign rd2_arr[gi] = req_rd2[gi*SIZE +: SIZE];
         assign op_arr[gi]  = req_op[gi*ALU_OPW +: ALU_OPW];
      end
   endgenerate

   logic            resp_valid_reg;
   logic [IDW-1:0]  resp_id_reg;
   logic [SIZE-1:0] resp_rez_reg;
   logic            resp_zero_reg;

   logic            can_accept;
   logic            grant_valid;
   logic [IDW-1:0]  grant_id;
   logic [SIZE-1:0] alu_rez;
   logic            alu_zero;

   assign can_accept = !resp_valid_reg || resp_ready;

   // Gating with reset keeps req_ready low during any reset cycle.
   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr (
      .clk         (clk),
      .reset       (reset),
      .en          (can_accept && !reset),
      .req         (req_valid),
      .grant       (req_ready),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   // grant_id is 0 without a grant, so the mux falls back to requester 0.
   alu #(
      .SIZE (SIZE)
   ) u_alu (
      .a    (rd1_arr[grant_id]),
      .b    (rd2_arr[grant_id]),
      .op   (op_arr[grant_id]),
      .rez  (alu_rez),
      .zero (alu_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid_reg <= 1'b0;
         resp_id_reg    <= '0;
         resp_rez_reg   <= '0;
         resp_zero_reg  <= 1'b0;
      end else if (grant_valid) begin
         resp_valid_reg <= 1'b1;
         resp_id_reg    <= grant_id;
         resp_rez_reg   <= alu_rez;
         resp_zero_reg  <= alu_zero;
      end else if (resp_valid_reg && resp_ready) begin
         resp_valid_reg <= 1'b0;
      end
   end

   assign resp_valid = resp_valid_reg;
   assign resp_id    = resp_id_reg;
   assign resp_rez   = resp_rez_reg;
   assign resp_zero  = resp_zero_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with hand-computed expectations.
module tb_alu_arbiter;
   localparam int SIZE = 32;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*SIZE-1:0] req_rd1;
   logic [NREQ*SIZE-1:0] req_rd2;
   logic [NREQ*4-1:0]    req_op;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [IDW-1:0]       resp_id;
   logic [SIZE-1:0]      resp_rez;
   logic                 resp_zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rd1    (req_rd1),
      .req_rd2    (req_rd2),
      .req_op     (req_op),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_rez   (resp_rez),
      .resp_zero  (resp_zero)
   );

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      req_rd1[i*SIZE +: SIZE] = a;
      req_rd2[i*SIZE +: SIZE] = b;
      req_op[i*4 +: 4]        = op;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      req_valid = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 4'b1111;
      resp_ready = 1'b1;
      req_rd1 = '0; req_rd2 = '0; req_op = '0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready);
      end
      reset = 1'b0;
      req_valid = '0;
      #1;
      checks++;
      if ({resp_valid, resp_id, resp_rez, resp_zero} !== '0) begin
         errors++; $display("FAIL reset_outputs got v=%b id=%0d rez=%h z=%b want all 0", resp_valid, resp_id, resp_rez, resp_zero);
      end
      $display("reset: resp_valid=%b req_ready=%b", resp_valid, req_ready);
   endtask

   task automatic test_single();
      @(negedge clk);
      set_req(0, 32'd5, 32'd3, 4'b0010);
      req_valid = 4'b0001;
      resp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL single_grant got %b want 0001", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_rez !== 32'd8 || resp_zero !== 1'b0) begin
         errors++; $display("FAIL single_resp got v=%b id=%0d rez=%h z=%b want v=1 id=0 rez=8 z=0", resp_valid, resp_id, resp_rez, resp_zero);
      end
      $display("single: id=%0d rez=%0d", resp_id, resp_rez);
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++; $display("FAIL single_drain got v=%b want 0", resp_valid);
      end
   endtask

   task automatic test_contention();
      logic [3:0] exp_grant;
      pulse_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'd100, 4'b0010);
      resp_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== IDW'((k-1) % 4) || resp_rez !== 32'(100 + (k-1) % 4)) begin
               errors++; $display("FAIL contention_resp%0d got v=%b id=%0d rez=%0d want v=1 id=%0d rez=%0d", k, resp_valid, resp_id, resp_rez, (k-1) % 4, 100 + (k-1) % 4);
            end
            $display("contention: resp id=%0d rez=%0d", resp_id, resp_rez);
         end
         if (k == 6) begin
            req_valid = '0;
         end else begin
            req_valid = 4'b1111;
            #1;
            exp_grant = 4'b0001 << (k % 4);
            checks++;
            if (req_ready !== exp_grant) begin
               errors++; $display("FAIL contention_grant%0d got %b want %b", k, req_ready, exp_grant);
            end
            @(negedge clk);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      // Pointer is 2 here; requester 0 is the only one asking, so it still wins.
      resp_ready = 1'b0;
      set_req(0, 32'd5, 32'd3, 4'b0010);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL bp_first_grant got %b want 0001", req_ready);
      end
      @(negedge clk);
      set_req(2, 32'd7, 32'd7, 4'b0110);
      req_valid = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_rez !== 32'd8) begin
            errors++; $display("FAIL bp_stall%0d got rdy=%b v=%b id=%0d rez=%0d want rdy=0000 v=1 id=0 rez=8", c, req_ready, resp_valid, resp_id, resp_rez);
         end
         $display("backpressure: stall cycle %0d", c);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL bp_release_grant got %b want 0100", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_rez !== 32'd0 || resp_zero !== 1'b1) begin
         errors++; $display("FAIL bp_resp got v=%b id=%0d rez=%h z=%b want v=1 id=2 rez=0 z=1", resp_valid, resp_id, resp_rez, resp_zero);
      end
      $display("backpressure: resp id=%0d rez=%0d z=%b", resp_id, resp_rez, resp_zero);
      @(negedge clk);
   endtask

   task automatic test_arith();
      logic [31:0] va [8] = '{32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFFFFF, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h5};
      logic [31:0] vb [8] = '{32'hFF00FF00, 32'h000000FF, 32'h1, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h3};
      logic [3:0]  vo [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b1100, 4'b1111};
      logic [31:0] vr [8] = '{32'hF000F000, 32'h0F0F00FF, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h0};
      logic        vz [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      resp_ready = 1'b1;
      for (int t = 0; t < 8; t++) begin
         set_req(0, va[t], vb[t], vo[t]);
         req_valid = 4'b0001;
         @(negedge clk);
         req_valid = '0;
         checks++;
         if (resp_valid !== 1'b1 || resp_rez !== vr[t] || resp_zero !== vz[t]) begin
            errors++; $display("FAIL arith%0d op=%b got v=%b rez=%h z=%b want v=1 rez=%h z=%b", t, vo[t], resp_valid, resp_rez, resp_zero, vr[t], vz[t]);
         end
         $display("arith: op=%b a=%h b=%h rez=%h z=%b", vo[t], va[t], vb[t], resp_rez, resp_zero);
      end
      @(negedge clk);
   endtask

   task automatic test_wrap();
      pulse_reset();
      resp_ready = 1'b1;
      set_req(1, 32'd1, 32'd1, 4'b0010);
      set_req(2, 32'd2, 32'd2, 4'b0010);
      req_valid = 4'b0100;
      @(negedge clk);
      req_valid = 4'b0110;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL wrap_grant got %b want 0010", req_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL skip_grant got %b want 0100", req_ready);
      end
      $display("wrap: grant=%b", req_ready);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      // Grant requester 2 first so a pointer that survives reset would be 3.
      resp_ready = 1'b0;
      set_req(2, 32'd5, 32'd3, 4'b0010);
      req_valid = 4'b0100;
      @(negedge clk);
      req_valid = '0;
      checks++;
      if (resp_valid !== 1'b1 || resp_rez !== 32'd8) begin
         errors++; $display("FAIL mid_pending got v=%b rez=%0d want v=1 rez=8", resp_valid, resp_rez);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({resp_valid, resp_id, resp_rez, resp_zero} !== '0) begin
         errors++; $display("FAIL mid_reset_outputs got v=%b id=%0d rez=%h z=%b want all 0", resp_valid, resp_id, resp_rez, resp_zero);
      end
      resp_ready = 1'b1;
      req_valid = 4'b1010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL mid_ptr_cleared got %b want 0010", req_ready);
      end
      req_valid = 4'b1000;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++; $display("FAIL mid_grant3 got %b want 1000", req_ready);
      end
      $display("reset_mid: grant=%b", req_ready);
      @(negedge clk);
      req_valid = '0;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd3) begin
         errors++; $display("FAIL mid_resp got v=%b id=%0d want v=1 id=3", resp_valid, resp_id);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_arith();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
